// File: rtl/aurora_bist_checker_pkg.sv
// Shared PRBS-64 definitions for the Aurora BIST generator and checker (package aurora_bist_pkg).
// Both sides import this package, so they always use the same polynomial.
package aurora_bist_pkg;

  localparam int BIST_W = 64;
  localparam int INC_W  = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    LOCKED = 2'd2
  } bist_chk_state_t;

  // x^64+x^63+x^61+x^60+1, advanced by one shift per word
  function automatic logic [BIST_W-1:0] prbs64_next(input logic [BIST_W-1:0] w);
    return {w[62:0], w[63] ^ w[62] ^ w[60] ^ w[59]};
  endfunction

  function automatic logic [INC_W-1:0] popcount64(input logic [BIST_W-1:0] w);
    logic [INC_W-1:0] c;
    c = '0;
    for (int i = 0; i < BIST_W; i++) c = c + INC_W'(w[i]);
    return c;
  endfunction

endpackage

// File: rtl/aurora_bist_checker_if.sv
// PHY RX word stream seen by the BIST checker.
// Handshake: a word transfers on every rising edge where s_axis_tvalid=1; there is no tready, so the sink never stalls.
interface aurora_bist_axis_if;
  import aurora_bist_pkg::*;

  logic [BIST_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;

  modport master (output s_axis_tdata, output s_axis_tvalid);
  modport slave  (input  s_axis_tdata, input  s_axis_tvalid);
endinterface

// File: rtl/aurora_bist_err_count.sv
// Saturating accumulator used for the checker's sample and error counters.
// Sticks at all-ones instead of wrapping; clear has priority over increment.
module aurora_bist_err_count #(
  parameter int CNT_W = 48,
  parameter int INC_W = 7
) (
  input  logic             phy_clk,
  input  logic             phy_rst_n,
  input  logic             clr,
  input  logic             inc_en,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W:0] sum;

  assign sum = {1'b0, count} + (CNT_W + 1)'(inc);

  always_ff @(posedge phy_clk) begin
    if (!phy_rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc_en) begin
      count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/aurora_bist_checker.sv
// PRBS-64 BIST checker: self-syncs to the RX word stream, then counts checked words and errors.
// Build option AURORA_BIST_BIT_ERR_COUNT_EN: count bit errors instead of word errors.
module aurora_bist_checker
  import aurora_bist_pkg::*;
#(
  parameter int LOCK_THRESH   = 16,
  parameter int UNLOCK_THRESH = 8,
  parameter int CNT_W         = 48
) (
  input  logic                 phy_clk,
  input  logic                 phy_rst_n,
  input  logic                 checker_en,
  aurora_bist_axis_if.slave    s_axis,
  output logic                 checker_locked,
  output logic [CNT_W-1:0]     checker_samps,
  output logic [CNT_W-1:0]     checker_errors,
  output bist_chk_state_t      checker_state
);

  localparam int MR_W = $clog2(LOCK_THRESH + 1);
  localparam int MS_W = $clog2(UNLOCK_THRESH + 1);

  bist_chk_state_t   state_q, state_d;
  logic [BIST_W-1:0] prev_q;
  logic              prev_ok_q;
  logic [MR_W-1:0]   match_run_q, match_run_d;
  logic [MS_W-1:0]   miss_run_q, miss_run_d;
  logic              locked_q;

  logic [BIST_W-1:0] exp_word;
  logic              beat_chk, match, miss;
  logic              cnt_clr, samp_inc, err_inc;
  logic [INC_W-1:0]  err_amt;

  assign exp_word = prbs64_next(prev_q);
  assign beat_chk = s_axis.s_axis_tvalid && prev_ok_q;
  // An all-zero word never matches, so an idle line cannot lock.
  assign match    = beat_chk && (s_axis.s_axis_tdata == exp_word) && (s_axis.s_axis_tdata != '0);
  assign miss     = beat_chk && !match;

`ifdef AURORA_BIST_BIT_ERR_COUNT_EN
  assign err_amt = popcount64(s_axis.s_axis_tdata ^ exp_word);
`else
  assign err_amt = INC_W'(1);
`endif

  always_comb begin
    state_d     = state_q;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    cnt_clr     = 1'b0;
    samp_inc    = 1'b0;
    err_inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        match_run_d = '0;
        miss_run_d  = '0;
        if (checker_en) begin
          state_d = SEEK;
          cnt_clr = 1'b1;
        end
      end
      SEEK: begin
        if (match) begin
          if (match_run_q == MR_W'(LOCK_THRESH - 1)) begin
            state_d     = LOCKED;
            match_run_d = '0;
            miss_run_d  = '0;
          end else begin
            match_run_d = match_run_q + 1'b1;
          end
        end else if (miss) begin
          match_run_d = '0;
        end
      end
      LOCKED: begin
        if (beat_chk) begin
          samp_inc = 1'b1;
          if (miss) begin
            err_inc = 1'b1;
            if (miss_run_q == MS_W'(UNLOCK_THRESH - 1)) begin
              state_d     = SEEK;
              match_run_d = '0;
              miss_run_d  = '0;
            end else begin
              miss_run_d = miss_run_q + 1'b1;
            end
          end else begin
            miss_run_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping the enable freezes the counters on the same edge.
    if (!checker_en) begin
      state_d     = IDLE;
      match_run_d = '0;
      miss_run_d  = '0;
      cnt_clr     = 1'b0;
      samp_inc    = 1'b0;
      err_inc     = 1'b0;
    end
  end

  always_ff @(posedge phy_clk) begin
    if (!phy_rst_n) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      prev_ok_q   <= 1'b0;
      match_run_q <= '0;
      miss_run_q  <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_run_q <= match_run_d;
      miss_run_q  <= miss_run_d;
      locked_q    <= (state_d == LOCKED);
      if (state_q != IDLE && s_axis.s_axis_tvalid) prev_q <= s_axis.s_axis_tdata;
      if (state_d == IDLE) prev_ok_q <= 1'b0;
      else if (state_q != IDLE && s_axis.s_axis_tvalid) prev_ok_q <= 1'b1;
    end
  end

  aurora_bist_err_count #(.CNT_W(CNT_W), .INC_W(INC_W)) u_samps (
    .phy_clk   (phy_clk),
    .phy_rst_n (phy_rst_n),
    .clr       (cnt_clr),
    .inc_en    (samp_inc),
    .inc       (INC_W'(1)),
    .count     (checker_samps)
  );

  aurora_bist_err_count #(.CNT_W(CNT_W), .INC_W(INC_W)) u_errors (
    .phy_clk   (phy_clk),
    .phy_rst_n (phy_rst_n),
    .clr       (cnt_clr),
    .inc_en    (err_inc),
    .inc       (err_amt),
    .count     (checker_errors)
  );

  assign checker_locked = locked_q;
  assign checker_state  = state_q;

endmodule

// File: tb/tb_aurora_bist_checker.sv
// Bench for aurora_bist_checker: random PRBS streams checked against a word-level reference model.
// A second instance with CNT_W=8 shares the stimulus to exercise counter saturation.
`timescale 1ns/1ps
module tb_aurora_bist_checker;
  import aurora_bist_pkg::*;

  localparam int LT = 16;
  localparam int UT = 8;
  localparam int CW = 48;

  logic phy_clk = 1'b0;
  logic phy_rst_n;
  logic checker_en;
  aurora_bist_axis_if bus ();

  logic            locked, locked8;
  logic [CW-1:0]   samps, errors;
  logic [7:0]      samps8, errors8;
  bist_chk_state_t st, st8;

  aurora_bist_checker #(.LOCK_THRESH(LT), .UNLOCK_THRESH(UT), .CNT_W(CW)) dut (
    .phy_clk(phy_clk), .phy_rst_n(phy_rst_n), .checker_en(checker_en), .s_axis(bus),
    .checker_locked(locked), .checker_samps(samps), .checker_errors(errors), .checker_state(st)
  );

  aurora_bist_checker #(.LOCK_THRESH(LT), .UNLOCK_THRESH(UT), .CNT_W(8)) dut8 (
    .phy_clk(phy_clk), .phy_rst_n(phy_rst_n), .checker_en(checker_en), .s_axis(bus),
    .checker_locked(locked8), .checker_samps(samps8), .checker_errors(errors8), .checker_state(st8)
  );

  // clock / reset
  always #5 phy_clk = ~phy_clk;

  int total = 0;
  int bad   = 0;

  // reference model: mode 0=idle, 1=seeking, 2=locked
  int              m_mode;
  logic [63:0]     m_prev;
  bit              m_prev_ok;
  int              m_mrun, m_xrun;
  longint unsigned m_samps, m_errs;
  logic [63:0]     src;

  function automatic logic [63:0] gen_next(input logic [63:0] w);
    logic fb;
    fb = ^(w & 64'hD800_0000_0000_0000);
    return {w[62:0], fb};
  endfunction

  function automatic longint unsigned err_weight(input logic [63:0] got, input logic [63:0] want);
`ifdef AURORA_BIST_BIT_ERR_COUNT_EN
    return longint'($countones(got ^ want));
`else
    return 1;
`endif
  endfunction

  function automatic logic [7:0] sat8(input longint unsigned v);
    return (v > 255) ? 8'hFF : v[7:0];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = '0; m_prev_ok = 0; m_mrun = 0; m_xrun = 0; m_samps = 0; m_errs = 0;
  endtask

  task automatic model_step(input bit en, input bit v, input logic [63:0] d);
    logic [63:0] want;
    bit ok;
    if (!en) begin
      m_mode = 0; m_prev_ok = 0; m_mrun = 0; m_xrun = 0;
      return;
    end
    if (m_mode == 0) begin
      m_mode = 1; m_samps = 0; m_errs = 0;
      return;
    end
    if (!v) return;
    if (m_prev_ok) begin
      want = gen_next(m_prev);
      ok = (d == want) && (d != 0);
      if (m_mode == 1) begin
        if (ok) begin
          m_mrun++;
          if (m_mrun == LT) begin m_mode = 2; m_mrun = 0; m_xrun = 0; end
        end else m_mrun = 0;
      end else begin
        m_samps++;
        if (ok) m_xrun = 0;
        else begin
          m_errs += err_weight(d, want);
          m_xrun++;
          if (m_xrun == UT) begin m_mode = 1; m_mrun = 0; m_xrun = 0; end
        end
      end
    end
    m_prev = d;
    m_prev_ok = 1;
  endtask

  // driver: present inputs, clock once, update model, sample #1 later
  task automatic tick(input bit en, input bit v, input logic [63:0] d);
    checker_en = en;
    bus.s_axis_tvalid = v;
    bus.s_axis_tdata = d;
    @(posedge phy_clk);
    if (!phy_rst_n) model_reset();
    else model_step(en, v, d);
    #1;
  endtask

  task automatic send_clean(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) tick(1, 0, $urandom);
      tick(1, 1, src);
      src = gen_next(src);
    end
  endtask

  task automatic restart(input logic [63:0] seed);
    tick(0, 0, '0);
    tick(1, 0, '0);
    src = seed;
  endtask

  task automatic test_reset();
    phy_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tick(1, 1, {$urandom, $urandom});
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0h want=0", locked); end
    total++; if (samps !== '0) begin bad++; $display("FAIL reset_samps got=%0h want=0", samps); end
    total++; if (errors !== '0) begin bad++; $display("FAIL reset_errors got=%0h want=0", errors); end
    total++; if (st !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", st, IDLE); end
    phy_rst_n = 1'b1;
  endtask

  task automatic test_lock_clean();
    restart(64'h1);
    send_clean(LT, 0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early got=%0h want=0", locked); end
    send_clean(1, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_at_17 got=%0h want=1", locked); end
    total++; if (samps !== '0) begin bad++; $display("FAIL lock_beat_counted got=%0h want=0", samps); end
    for (int i = 1; i <= 5; i++) begin
      send_clean(1, 0);
      total++; if (samps !== CW'(i)) begin bad++; $display("FAIL lock_samps got=%0h want=%0h", samps, i); end
    end
    total++; if (errors !== '0) begin bad++; $display("FAIL lock_errors got=%0h want=0", errors); end
  endtask

  task automatic test_zero_stream();
    bit seen = 0;
    restart(64'h0);
    for (int i = 0; i < 1000; i++) begin
      tick(1, 1, 64'h0);
      if (locked !== 1'b0) seen = 1;
    end
    total++; if (seen) begin bad++; $display("FAIL zero_locked got=1 want=0"); end
    total++; if (samps !== '0 || errors !== '0) begin bad++; $display("FAIL zero_counts got=%0h/%0h want=0/0", samps, errors); end
  endtask

  task automatic test_bit_flip();
    logic [CW-1:0] e0;
    int k;
    restart({$urandom, $urandom} | 64'h1);
    send_clean(LT + 1 + 3, 0);
    e0 = errors;
    tick(1, 1, src ^ (64'h1 << 5));
    src = gen_next(src);
    total++; if (errors !== CW'(e0 + 1)) begin bad++; $display("FAIL flip1_errors got=%0h want=%0h", errors, e0 + 1); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL flip1_locked got=%0h want=1", locked); end
    send_clean(20, 0);
    e0 = errors;
    k = $urandom_range(0, 62);
    tick(1, 1, src ^ (64'h3 << k));
    src = gen_next(src);
`ifdef AURORA_BIST_BIT_ERR_COUNT_EN
    total++; if (errors !== CW'(e0 + 2)) begin bad++; $display("FAIL flip2_errors got=%0h want=%0h", errors, e0 + 2); end
`else
    total++; if (errors !== CW'(e0 + 1)) begin bad++; $display("FAIL flip2_errors got=%0h want=%0h", errors, e0 + 1); end
`endif
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL flip2_locked got=%0h want=1", locked); end
    send_clean(5, 0);
    total++; if (errors !== CW'(m_errs) || samps !== CW'(m_samps)) begin
      bad++; $display("FAIL flip_model got=%0h/%0h want=%0h/%0h", samps, errors, m_samps, m_errs); end
  endtask

  task automatic test_unlock_relock();
    logic [CW-1:0] e0;
    int n;
    e0 = errors;
    for (int i = 1; i <= UT; i++) begin
      if (i == UT) begin
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL unlock_early got=%0h want=1", locked); end
      end
      tick(1, 1, src ^ ({$urandom, $urandom} | 64'h1));
      src = gen_next(src);
    end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL unlock_locked got=%0h want=0", locked); end
`ifndef AURORA_BIST_BIT_ERR_COUNT_EN
    total++; if (errors !== CW'(e0 + UT)) begin bad++; $display("FAIL unlock_errors got=%0h want=%0h", errors, e0 + UT); end
`endif
    total++; if (errors !== CW'(m_errs)) begin bad++; $display("FAIL unlock_model got=%0h want=%0h", errors, m_errs); end
    n = 0;
    while (locked !== 1'b1 && n < 40) begin send_clean(1, 0); n++; end
    total++; if (n != LT + 1) begin bad++; $display("FAIL relock_beats got=%0d want=%0d", n, LT + 1); end
  endtask

  task automatic test_gaps();
    restart({$urandom, $urandom} | 64'h1);
    send_clean(LT, 2);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL gap_early got=%0h want=0", locked); end
    send_clean(1, 2);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL gap_lock got=%0h want=1", locked); end
    send_clean(30, 2);
    total++; if (samps !== CW'(30)) begin bad++; $display("FAIL gap_samps got=%0h want=1e", samps); end
    total++; if (errors !== '0) begin bad++; $display("FAIL gap_errors got=%0h want=0", errors); end
  endtask

  task automatic test_en_toggle();
    logic [CW-1:0] s0, e0;
    tick(1, 1, src ^ 64'h10);
    src = gen_next(src);
    s0 = samps; e0 = errors;
    tick(0, 1, src);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL en_off_locked got=%0h want=0", locked); end
    for (int i = 0; i < 4; i++) tick(0, 1, {$urandom, $urandom});
    total++; if (samps !== s0 || errors !== e0) begin
      bad++; $display("FAIL en_off_hold got=%0h/%0h want=%0h/%0h", samps, errors, s0, e0); end
    tick(1, 0, '0);
    total++; if (samps !== '0 || errors !== '0) begin
      bad++; $display("FAIL en_on_clear got=%0h/%0h want=0/0", samps, errors); end
  endtask

  task automatic test_saturate();
    restart({$urandom, $urandom} | 64'h1);
    send_clean(LT + 1 + 300, 0);
    total++; if (samps8 !== 8'hFF) begin bad++; $display("FAIL sat_samps8 got=%0h want=ff", samps8); end
    total++; if (samps8 !== sat8(m_samps)) begin bad++; $display("FAIL sat_model8 got=%0h want=%0h", samps8, sat8(m_samps)); end
    total++; if (samps !== CW'(300)) begin bad++; $display("FAIL sat_samps48 got=%0h want=12c", samps); end
    total++; if (locked8 !== 1'b1 || errors8 !== 8'h0) begin
      bad++; $display("FAIL sat_lock8 got=%0h/%0h want=1/0", locked8, errors8); end
  endtask

  initial begin
    phy_rst_n = 1'b0;
    checker_en = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata = '0;
    model_reset();
    test_reset();
    test_lock_clean();
    test_zero_stream();
    test_bit_flip();
    test_unlock_relock();
    test_gaps();
    test_en_toggle();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
